mem_port_arbiter: RTL

//  Shares the single-port unified memory between instruction fetch (IF) and the

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 18 +
 rtl/mem_port_arbiter_starve.sv | 29 ++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// State and grant encodings are reused by the hazard unit and the bench.
package mem_port_arbiter_pkg;

   localparam int ADDR_W         = 32;
   localparam int DATA_W         = 16;
   localparam int DEF_MAX_STARVE = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY_IF = 2'd1,
      ST_BUSY_LS = 2'd2,
      ST_RESP    = 2'd3
   } arb_state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_LS = 1'b1
   } arb_gnt_e;

   function automatic int starve_width(input int max_starve);
      return $clog2(max_starve + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response port used for the IF, LS and memory sides of the arbiter.
// The requester owns req/we/addr/wdata; the responder owns ack/rdata.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW = ADDR_W,
   parameter int DW = DATA_W
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ack;
   logic [DW-1:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_port_arbiter_starve.sv
// Saturating count of LS grants taken while IF was waiting.
// sat_o tells the arbiter IF must win the next contested grant.
module arb_starve_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_STARVE = DEF_MAX_STARVE
) (
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);
   localparam int W = starve_width(MAX_STARVE);

   logic [W-1:0] cnt_q;

   assign sat_o = (cnt_q >= W'(MAX_STARVE));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && !sat_o) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and load/store.
// state      | meaning
// ST_IDLE    | no transaction; grant decided here (LS first unless IF is starved)
// ST_BUSY_IF | fetch issued to memory, waiting for mem ack
// ST_BUSY_LS | load/store issued to memory, waiting for mem ack
// ST_RESP    | one-cycle ack to the granted requester, no grant
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_STARVE = DEF_MAX_STARVE
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  if_port,
   mem_port_arbiter_if.slave  ls_port,
   mem_port_arbiter_if.master mem_port,
   output logic               if_stall_o,
   output logic               ls_stall_o
);
   arb_state_e        state_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              if_ack_q;
   logic              ls_ack_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] ls_rdata_q;

   logic     starve_sat;
   logic     starve_inc;
   logic     starve_clr;
   logic     grant_vld;
   arb_gnt_e grant_id;

   always_comb begin
      grant_vld  = 1'b0;
      grant_id   = GNT_IF;
      starve_inc = 1'b0;
      starve_clr = 1'b0;
      if (state_q == ST_IDLE) begin
         if (ls_port.req && (!if_port.req || !starve_sat)) begin
            grant_vld  = 1'b1;
            grant_id   = GNT_LS;
            starve_inc = if_port.req;
         end else if (if_port.req) begin
            grant_vld  = 1'b1;
            grant_id   = GNT_IF;
            starve_clr = 1'b1;
         end
      end
   end

   arb_starve_counter #(.MAX_STARVE(MAX_STARVE)) u_starve (
      .clk   (clk),
      .rst   (rst),
      .inc_i (starve_inc),
      .clr_i (starve_clr),
      .sat_o (starve_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         ls_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_vld) begin
                  mem_req_q <= 1'b1;
                  if (grant_id == GNT_LS) begin
                     state_q     <= ST_BUSY_LS;
                     mem_we_q    <= ls_port.we;
                     mem_addr_q  <= ls_port.addr;
                     mem_wdata_q <= ls_port.wdata;
                  end else begin
                     state_q     <= ST_BUSY_IF;
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= if_port.addr;
                     mem_wdata_q <= '0;
                  end
               end
            end
            ST_BUSY_IF: begin
               if (mem_port.ack) begin
                  if_rdata_q <= mem_port.rdata;
                  if_ack_q   <= 1'b1;
                  mem_req_q  <= 1'b0;
                  state_q    <= ST_RESP;
               end
            end
            ST_BUSY_LS: begin
               if (mem_port.ack) begin
                  // writes leave the last loaded word visible
                  if (!mem_we_q) ls_rdata_q <= mem_port.rdata;
                  ls_ack_q  <= 1'b1;
                  mem_req_q <= 1'b0;
                  state_q   <= ST_RESP;
               end
            end
            ST_RESP: begin
               if_ack_q <= 1'b0;
               ls_ack_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mem_port.req   = mem_req_q;
   assign mem_port.we    = mem_we_q;
   assign mem_port.addr  = mem_addr_q;
   assign mem_port.wdata = mem_wdata_q;
   assign if_port.ack    = if_ack_q;
   assign if_port.rdata  = if_rdata_q;
   assign ls_port.ack    = ls_ack_q;
   assign ls_port.rdata  = ls_rdata_q;

   assign if_stall_o = if_port.req & ~if_ack_q;
   assign ls_stall_o = ls_port.req & ~ls_ack_q;
endmodule
